register_file: RTL and testbench

- Small multi-ported general-purpose register file for the 8-bit CPU datapath.
- Two combinational read ports (rs1, rs2) feed the ALU operand paths.
- One synchronous write port is driven from the writeback stage.
- Default configuration: 4 registers x 8 bits, all cleared by reset.

---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file_read_port.sv | 32 +++
 rtl/register_file.sv | 81 ++++++++
 tb/tb_register_file.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared sizing constants and types for the CPU register file.
// Optional build macro: REGFILE_WRITE_BYPASS_EN (write-to-read forwarding).
package register_file_pkg;

  localparam int REGFILE_DATA_WIDTH = 8;
  localparam int REGFILE_ADDR_WIDTH = 2;
  localparam int REGFILE_NUM_REGS   = 2 ** REGFILE_ADDR_WIDTH;

  typedef logic [REGFILE_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REGFILE_DATA_WIDTH-1:0] reg_data_t;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// One combinational read port of the register file: an address mux over the
// stored registers plus, when REGFILE_WRITE_BYPASS_EN is defined, a compare
// against the write port that forwards the incoming write data.
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_i,
  input  logic [ADDR_WIDTH-1:0]               rd_addr_i,
`ifdef REGFILE_WRITE_BYPASS_EN
  // byp_en_i is already qualified with reset by the caller.
  input  logic                                byp_en_i,
  input  logic [ADDR_WIDTH-1:0]               byp_addr_i,
  input  logic [DATA_WIDTH-1:0]               byp_data_i,
`endif
  output logic [DATA_WIDTH-1:0]               rd_data_o
);

  // Select stored contents, overridden by a same-cycle write to this address.
  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (byp_en_i && (byp_addr_i == rd_addr_i)) begin
      rd_data_o = byp_data_i;
    end
`endif
  end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// General-purpose register file: NUM_REGS x DATA_WIDTH, two combinational
// read ports, one synchronous write port, synchronous active-high reset that
// wins over a concurrent write. Register 0 is an ordinary writable register.
// Optional build macro: REGFILE_WRITE_BYPASS_EN forwards wr_data to a read
// port whose address matches an active write in the same cycle.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  reg_wr_en,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;

  // Next-state: only the addressed register changes on an enabled write.
  always_comb begin
    regs_d = regs_q;
    if (reg_wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Storage: reset clears everything and discards any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  // A write that reset is about to discard must not be forwarded either.
  logic byp_en;
  assign byp_en = reg_wr_en & ~reset;
`endif

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rs1_port (
    .regs_i     (regs_q),
    .rd_addr_i  (rs1_addr),
`ifdef REGFILE_WRITE_BYPASS_EN
    .byp_en_i   (byp_en),
    .byp_addr_i (wr_addr),
    .byp_data_i (wr_data),
`endif
    .rd_data_o  (rs1_data)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rs2_port (
    .regs_i     (regs_q),
    .rd_addr_i  (rs2_addr),
`ifdef REGFILE_WRITE_BYPASS_EN
    .byp_en_i   (byp_en),
    .byp_addr_i (wr_addr),
    .byp_data_i (wr_data),
`endif
    .rd_data_o  (rs2_data)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed testbench for register_file: a linear sequence of hand-computed
// vectors covering reset priority, writes, dual reads and same-cycle collision.
module tb_register_file;

  logic       clk;
  logic       reset;
  logic [1:0] rs1_addr;
  logic [1:0] rs2_addr;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       reg_wr_en;
  logic [7:0] rs1_data;
  logic [7:0] rs2_data;

  int vectors;
  int miscompares;

  register_file dut (
    .clk       (clk),
    .reset     (reset),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .reg_wr_en (reg_wr_en),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then move off the edge before touching anything.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both read addresses and let the combinational read settle.
  task automatic rd(input logic [1:0] a1, input logic [1:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] coll_exp;
    vectors     = 0;
    miscompares = 0;

    // Reset held two edges with a write pending to reg2.
    reset     = 1'b1;
    reg_wr_en = 1'b1;
    wr_addr   = 2'd2;
    wr_data   = 8'hAA;
    rs1_addr  = 2'd0;
    rs2_addr  = 2'd1;
    tick();
    rd(2'd0, 2'd1);
    check("rst_r0", rs1_data, 8'h00);
    check("rst_r1", rs2_data, 8'h00);
    tick();
    rd(2'd2, 2'd3);
    check("rst_r2_discard", rs1_data, 8'h00);
    check("rst_r3", rs2_data, 8'h00);

    // Release reset with the write still enabled.
    reset = 1'b0;
    tick();
    rd(2'd2, 2'd0);
    check("post_rst_r2", rs1_data, 8'hAA);
    check("post_rst_r0", rs2_data, 8'h00);
    rd(2'd1, 2'd3);
    check("post_rst_r1", rs1_data, 8'h00);
    check("post_rst_r3", rs2_data, 8'h00);

    // Write reg0 (fully writable) and read back.
    wr_addr = 2'd0;
    wr_data = 8'hAE;
    tick();
    rd(2'd0, 2'd1);
    check("wr0_rs1", rs1_data, 8'hAE);
    check("wr0_rs2", rs2_data, 8'h00);

    // Write reg1, cross read.
    wr_addr = 2'd1;
    wr_data = 8'hCC;
    tick();
    rd(2'd2, 2'd1);
    check("cross_rs1", rs1_data, 8'hAA);
    check("cross_rs2", rs2_data, 8'hCC);
    rd(2'd1, 2'd1);
    check("same_addr_rs1", rs1_data, 8'hCC);
    check("same_addr_rs2", rs2_data, 8'hCC);

    // Same-cycle collision on reg3 via port 1; port 2 reads an unrelated reg.
    wr_addr = 2'd3;
    wr_data = 8'h5A;
`ifdef REGFILE_WRITE_BYPASS_EN
    coll_exp = 8'h5A;
`else
    coll_exp = 8'h00;
`endif
    rd(2'd3, 2'd0);
    check("collide_before", rs1_data, coll_exp);
    check("collide_other_port", rs2_data, 8'hAE);
    tick();
    reg_wr_en = 1'b0;
    rd(2'd3, 2'd3);
    check("collide_after_rs1", rs1_data, 8'h5A);
    check("collide_after_rs2", rs2_data, 8'h5A);

    // Write disabled: data and address present, nothing must change.
    wr_addr = 2'd0;
    wr_data = 8'hFF;
    rd(2'd0, 2'd0);
    check("wr_dis_before", rs1_data, 8'hAE);
    tick();
    rd(2'd0, 2'd2);
    check("wr_dis_r0", rs1_data, 8'hAE);
    check("wr_dis_r2", rs2_data, 8'hAA);

    // Mid-run reset with an in-flight write: not forwarded, not stored.
    reset     = 1'b1;
    reg_wr_en = 1'b1;
    wr_addr   = 2'd1;
    wr_data   = 8'h77;
    rd(2'd1, 2'd2);
    check("rst_mid_no_fwd", rs1_data, 8'hCC);
    tick();
    reset     = 1'b0;
    reg_wr_en = 1'b0;
    rd(2'd0, 2'd1);
    check("rst_mid_r0", rs1_data, 8'h00);
    check("rst_mid_r1", rs2_data, 8'h00);
    rd(2'd2, 2'd3);
    check("rst_mid_r2", rs1_data, 8'h00);
    check("rst_mid_r3", rs2_data, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_register_file
